// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Each op does 32 one-bit iterations plus one sign-fix/writeback cycle.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  // Per-op context latched at launch: result signs and the divide-by-zero flag.
  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_hi;
    logic dz;
  } ctx_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  ctx_t               ctx;

  logic               accept, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum, rsh, diff;
  logic               ge;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = (state == S_IDLE) && start && !cancel;
  assign sa     = ~op[0] & A[WIDTH-1];
  assign sb     = ~op[0] & B[WIDTH-1];
  assign mag_a  = sa ? -A : A;
  assign mag_b  = sb ? -B : B;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_RUN;
      S_RUN:    if (cancel) state_nx = S_IDLE;
                else if (cnt == CNT_W'(WIDTH-1)) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // One iteration: acc is {partial product, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide.
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rsh  = acc[2*WIDTH-1:WIDTH-1];
    ge   = (rsh >= {1'b0, opb});
    diff = rsh - {1'b0, opb};
    step = {msum, acc[WIDTH-1:1]};
    if (ctx.is_div)
      step = ge ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                : {rsh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction; a zero divisor forces an all-ones quotient regardless of sign.
  always_comb begin
    prod   = ctx.neg_lo ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (ctx.is_div) begin
      res_lo = ctx.dz ? '1 : (ctx.neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      res_hi = ctx.neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      ctx   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == S_FINISH) && !cancel;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt        <= '0;
            acc        <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            opb        <= op[1] ? mag_b : mag_a;
            ctx.is_div <= op[1];
            ctx.neg_lo <= sa ^ sb;
            ctx.neg_hi <= sa;
            ctx.dz     <= (B == '0);
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        S_FINISH: begin
          if (!cancel) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits in the EX stage beside the single-cycle ALU.
- It owns the architectural HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.
- It runs a start/busy/done handshake; the hazard unit stalls any HI/LO consumer while busy=1.
- Ops run for a fixed 32 iterations, one bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch an op; sampled only when busy=0
- op  in  2  operation: 00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- A  in  WIDTH  rs operand (multiplicand / dividend)
- B  in  WIDTH  rt operand (multiplier / divisor)
- cancel  in  1  abort in-flight op (exception flush)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  op in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal shift registers cleared. Takes effect immediately, including mid-op; the in-flight result is discarded.
- States:
  - IDLE: on start=1, go to RUN. At the same edge, latch operands as magnitudes (signed ops take the absolute value and record the result sign), latch op, clear counter.
  - RUN: one iteration per cycle. Multiply is shift-add on a 2*WIDTH accumulator. Divide is restoring, one quotient bit per cycle.
  - RUN -> FINISH when the counter reaches WIDTH-1.
  - FINISH: apply sign correction, write hi/lo, pulse done=1, return to IDLE. busy=0 in the cycle done=1.
- Latency: start sampled at edge N; busy=1 from after edge N until edge N+33; hi/lo hold the new values and done=1 after edge N+33. Total 33 cycles.
- Multiply results:
  - {hi,lo} = full 64-bit product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no trap).
  - Divide by zero (B=0), both DIV and DIVU: lo=0xFFFFFFFF, hi=A. Still takes the full 33 cycles.
- start while busy=1: ignored; no queueing.
- cancel=1 while busy=1: return to IDLE at the next edge; hi/lo unchanged; no done pulse.
- cancel=1 while idle: no effect, and start in the same cycle is suppressed.
- MTHI/MTLO:
  - hi_we/lo_we update hi/lo at the next edge only when busy=0 and start=0.
  - While busy=1 the writes are dropped; the pipeline must stall them.
  - start and hi_we in the same idle cycle: start wins, write is dropped.
- FINISH cycle: hi_we/lo_we are ignored; the op result wins.
- hi/lo are stable and readable at all times except at the result edge.

Test Plan:
- Reset mid-RUN: start MULTU A=3 B=5, assert rst at cycle 10 -> busy=0, hi=0, lo=0 immediately; no done pulse.
- MULT A=0xFFFFFFFE (-2), B=3 -> done after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=7, B=2 -> lo=3, hi=1.
- DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234 at cycle 33. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - Second start at cycle 5 of an op -> ignored; only one done pulse.
  - hi_we=1 wdata=0xAAAA5555 while busy -> hi keeps the op result.
  - Same write while idle -> hi=0xAAAA5555 next cycle.
- cancel at cycle 20 of MULTU 0xFFFFFFFF*0xFFFFFFFF (hi/lo preloaded with 1/2) -> busy drops next cycle, hi=1, lo=2, no done. A fresh start then completes normally: hi=0xFFFFFFFE, lo=0x00000001.
